// File: rtl/usb_tx_pkg.sv
// Shared USB transmit-path types and constants.
package usb_tx_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        STUFF
    } nrzi_state_t;

    localparam int   USB_STUFF_LEN = 6;
    localparam logic NRZI_J        = 1'b1;

endpackage

// File: rtl/stuff_ones_counter.sv
// Saturating run-of-ones counter used to decide when a stuff bit is due.
module stuff_ones_counter #(
    parameter  int STUFF_LEN = 6,
    localparam int W         = $clog2(STUFF_LEN + 1)
) (
    input  logic clock,
    input  logic reset_n,
    input  logic inc,
    input  logic clr,
    output logic hit,
    output logic will_hit
);

    logic [W-1:0] ones_q;
    logic [W-1:0] ones_d;

    always_comb begin
        ones_d = ones_q;
        if (clr) begin
            ones_d = '0;
        end else if (inc && ones_q < W'(STUFF_LEN)) begin
            ones_d = ones_q + W'(1);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ones_q <= '0;
        end else begin
            ones_q <= ones_d;
        end
    end

    assign hit      = (ones_q == W'(STUFF_LEN));
    // Lets the FSM enter STUFF on the same edge that accepts the last 1.
    assign will_hit = inc & ~clr & (ones_q == W'(STUFF_LEN - 1));

endmodule

// File: rtl/nrzi_stuff_encode.sv
// USB transmit bit stuffer and NRZI encoder feeding the line driver.
module nrzi_stuff_encode
    import usb_tx_pkg::*;
#(
    parameter int STUFF_LEN = USB_STUFF_LEN
) (
    input  logic clock,
    input  logic reset_n,
    input  logic in_bit,
    input  logic in_valid,
    output logic in_pause,
    output logic nrzi_out_bit,
    output logic nrzi_sending,
    output logic stuff_event
);

    nrzi_state_t state_q;
    nrzi_state_t state_d;

    logic level_q;
    logic level_d;
    logic out_bit_q;
    logic out_bit_d;
    logic sending_q;
    logic sending_d;
    logic stuff_ev_q;
    logic stuff_ev_d;

    logic accept;
    logic stuffing;
    logic data_ev;
    logic data_bit;
    logic new_lvl;
    logic enter_idle;
    logic cnt_inc;
    logic cnt_clr;
    logic hit;
    logic will_hit;

    stuff_ones_counter #(
        .STUFF_LEN(STUFF_LEN)
    ) u_ones (
        .clock   (clock),
        .reset_n (reset_n),
        .inc     (cnt_inc),
        .clr     (cnt_clr),
        .hit     (hit),
        .will_hit(will_hit)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = will_hit ? STUFF : SEND;
                end
            end
            SEND: begin
                if (!in_valid) begin
                    state_d = IDLE;
                end else if (will_hit) begin
                    state_d = STUFF;
                end
            end
            STUFF: begin
                state_d = in_valid ? SEND : IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        in_pause = (state_q == STUFF);
    end

    always_comb begin
        accept     = in_valid & ~in_pause;
        stuffing   = (state_q == STUFF);
        data_ev    = accept | stuffing;
        data_bit   = stuffing ? 1'b0 : in_bit;
        new_lvl    = data_bit ? level_q : ~level_q;
        enter_idle = (state_q != IDLE) && (state_d == IDLE);
        cnt_inc    = accept & in_bit;
        cnt_clr    = hit | (accept & ~in_bit) | enter_idle;
        // The line keeps its last level; only the internal reference rewinds to J.
        level_d    = enter_idle ? NRZI_J : (data_ev ? new_lvl : level_q);
        out_bit_d  = data_ev ? new_lvl : out_bit_q;
        sending_d  = data_ev;
        stuff_ev_d = stuffing;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            level_q    <= NRZI_J;
            out_bit_q  <= NRZI_J;
            sending_q  <= 1'b0;
            stuff_ev_q <= 1'b0;
        end else begin
            level_q    <= level_d;
            out_bit_q  <= out_bit_d;
            sending_q  <= sending_d;
            stuff_ev_q <= stuff_ev_d;
        end
    end

    assign nrzi_out_bit = out_bit_q;
    assign nrzi_sending = sending_q;
    assign stuff_event  = stuff_ev_q;

endmodule
